// File: rtl/serial_button_pkg.sv
// Shared types, defaults and width helper for the serial button receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_button_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DEF_NUM_BUTTONS     = 8;
    localparam int DEF_BIT_PERIOD      = 200;
    localparam int DEF_SAMPLE_POINT    = 100;
    localparam int DEF_DEBOUNCE_FRAMES = 2;
    localparam int DEF_TIMEOUT_CYCLES  = 100000;

    // Counter wide enough to hold max_val itself (saturation value included).
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/line_sync_edge.sv
// Two-flop synchroniser for the serial line plus falling-edge detector.
// Latency: 2 cycles to line, falling-edge pulse valid in the same cycle as line.
// Backpressure: none; free-running sampler, flops reset to the idle-high level.
module line_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic line,
    output logic fall
);

    logic sync_q1;
    logic sync_q2;
    logic line_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1   <= 1'b1;
            sync_q2   <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_q1   <= din;
            sync_q2   <= sync_q1;
            line_prev <= sync_q2;
        end
    end

    assign line = sync_q2;
    assign fall = line_prev & ~sync_q2;

endmodule

// File: rtl/serial_button_rx.sv
// Framed serial button receiver: start/data/stop framing, frame debounce, link watchdog.
// Latency: buttons/buttons_valid/frame_error update one cycle after the stop-bit sample.
// Backpressure: none; outputs are single-cycle pulses and level state, never stalled.
module serial_button_rx
    import serial_button_pkg::*;
#(
    parameter int NUM_BUTTONS     = DEF_NUM_BUTTONS,
    parameter int BIT_PERIOD      = DEF_BIT_PERIOD,
    parameter int SAMPLE_POINT    = DEF_SAMPLE_POINT,
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   readline,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic                   buttons_valid,
    output logic                   frame_error,
    output logic                   link_ok
);

    localparam int TMR_W = cnt_width(BIT_PERIOD);
    localparam int BIT_W = cnt_width(NUM_BUTTONS);
    localparam int MCH_W = cnt_width(DEBOUNCE_FRAMES);
    localparam int WD_W  = cnt_width(TIMEOUT_CYCLES);

    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(BIT_PERIOD - 1);
    localparam logic [TMR_W-1:0] TMR_SAMPLE = TMR_W'(SAMPLE_POINT);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_BUTTONS - 1);
    localparam logic [MCH_W-1:0] MCH_FULL   = MCH_W'(DEBOUNCE_FRAMES);
    localparam logic [MCH_W-1:0] MCH_ONE    = MCH_W'(1);
    localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_PRE     = WD_W'(TIMEOUT_CYCLES - 1);

    logic                   line_s;
    logic                   line_fall;

    rx_state_t              state;
    rx_state_t              state_nxt;
    logic [TMR_W-1:0]       bit_timer;
    logic [BIT_W-1:0]       bit_cnt;
    logic [NUM_BUTTONS-1:0] shift_reg;
    logic [NUM_BUTTONS:0]   shift_ext;

    logic                   sample_stb;
    logic                   timer_clr;
    logic                   bit_clr;
    logic                   shift_en;
    logic                   good_frame;
    logic                   bad_frame;

    logic [NUM_BUTTONS-1:0] cand;
    logic [NUM_BUTTONS-1:0] cand_nxt;
    logic [MCH_W-1:0]       match_cnt;
    logic [MCH_W-1:0]       match_nxt;
    logic                   publish;

    logic [WD_W-1:0]        wd_cnt;

    line_sync_edge u_line_sync_edge (
        .clk   (clk),
        .reset (reset),
        .din   (readline),
        .line  (line_s),
        .fall  (line_fall)
    );

    assign sample_stb = (bit_timer == TMR_SAMPLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Falling edges only matter in IDLE; the other states watch the sample strobe.
    always_comb begin
        state_nxt  = state;
        timer_clr  = 1'b0;
        bit_clr    = 1'b0;
        shift_en   = 1'b0;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        case (state)
            IDLE: begin
                if (line_fall) begin
                    state_nxt = START;
                    timer_clr = 1'b1;
                end
            end
            START: begin
                if (sample_stb) begin
                    if (!line_s) begin
                        state_nxt = DATA;
                        bit_clr   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample_stb) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (sample_stb) begin
                    state_nxt  = IDLE;
                    good_frame = line_s;
                    bad_frame  = ~line_s;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign shift_ext = {shift_reg, line_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_timer <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (timer_clr || bit_timer == TMR_LAST) begin
                bit_timer <= '0;
            end else begin
                bit_timer <= bit_timer + 1'b1;
            end

            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (shift_en) begin
                shift_reg <= shift_ext[NUM_BUTTONS-1:0];
            end
        end
    end

    // Publish only when the run of identical frames completes and actually changes state.
    always_comb begin
        cand_nxt  = cand;
        match_nxt = match_cnt;
        publish   = 1'b0;
        if (good_frame) begin
            if (shift_reg == cand) begin
                if (match_cnt != MCH_FULL) begin
                    match_nxt = match_cnt + 1'b1;
                end
            end else begin
                cand_nxt  = shift_reg;
                match_nxt = MCH_ONE;
            end
            publish = (match_nxt == MCH_FULL) && (cand_nxt != buttons);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand          <= '0;
            match_cnt     <= '0;
            buttons       <= '0;
            buttons_valid <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            cand          <= cand_nxt;
            match_cnt     <= match_nxt;
            buttons_valid <= publish;
            frame_error   <= bad_frame;
            if (publish) begin
                buttons <= cand_nxt;
            end
        end
    end

    // link_ok falls in the same cycle the counter lands on TIMEOUT_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt  <= '0;
            link_ok <= 1'b0;
        end else if (good_frame) begin
            wd_cnt  <= '0;
            link_ok <= 1'b1;
        end else if (wd_cnt != WD_LIMIT) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WD_PRE) begin
                link_ok <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_button_rx.sv
// Directed bench for serial_button_rx: expected publish/error events queue up as frames
// are sent; a negedge monitor pops and compares them against the DUT pulses.
module tb_serial_button_rx;
    import serial_button_pkg::*;

    localparam int NB = 8;
    localparam int BP = 16;
    localparam int SP = 8;
    localparam int DF = 2;
    localparam int TO = 1000;
    // Start bit driven in cycle k: sync 2 + START entry 1 + SP to start strobe,
    // then 9 more bit periods to the stop strobe, outputs one cycle later.
    localparam int LAT = 156;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       readline;
    logic [7:0] buttons;
    logic       buttons_valid;
    logic       frame_error;
    logic       link_ok;

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    ev_t sb_q[$];

    serial_button_rx #(
        .NUM_BUTTONS     (NB),
        .BIT_PERIOD      (BP),
        .SAMPLE_POINT    (SP),
        .DEBOUNCE_FRAMES (DF),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .readline      (readline),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .frame_error   (frame_error),
        .link_ok       (link_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT pulse must match the head of the expected-event queue.
    always @(negedge clk) begin
        if (buttons_valid || frame_error) begin
            if (sb_q.size() == 0) begin
                check("spurious_evt", int'({frame_error, buttons_valid}), 0);
            end else begin
                ev_t e;
                e = sb_q.pop_front();
                check("evt_kind", int'(frame_error), int'(e.is_err));
                check("evt_cycle", cyc, e.cyc);
                if (!e.is_err) begin
                    check("evt_buttons", int'(buttons), int'(e.data));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put_bit(input logic b);
        readline = b;
        idle(BP);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input bit exp_pub);
        ev_t e;
        if (exp_pub || !stop) begin
            e.is_err = !stop;
            e.data   = d;
            e.cyc    = cyc + LAT;
            sb_q.push_back(e);
        end
        put_bit(1'b0);
        for (int i = NB - 1; i >= 0; i--) begin
            put_bit(d[i]);
        end
        put_bit(stop);
        readline = 1'b1;
        idle(4);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(4);
    endtask

    initial begin
        int rise_cyc;
        readline = 1'b1;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_buttons", int'(buttons), 0);
        check("rst_valid", int'(buttons_valid), 0);
        check("rst_ferr", int'(frame_error), 0);
        check("rst_link", int'(link_ok), 0);
        check("rst_state", int'(dut.state), int'(IDLE));
        reset = 1'b0;
        idle(4);

        // Two identical frames publish on the second.
        send_frame(8'hA5, 1'b1, 1'b0);
        check("t1_hold", int'(buttons), 8'h00);
        check("t1_link", int'(link_ok), 1);
        send_frame(8'hA5, 1'b1, 1'b1);
        check("t1_buttons", int'(buttons), 8'hA5);

        // Interleaved frame breaks the run.
        apply_reset();
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("t2_hold", int'(buttons), 8'h00);
        send_frame(8'hA5, 1'b1, 1'b1);
        check("t2_buttons", int'(buttons), 8'hA5);

        // Short low glitch aborts in START silently.
        readline = 1'b0;
        idle(4);
        readline = 1'b1;
        idle(30);
        check("t3_state", int'(dut.state), int'(IDLE));
        check("t3_buttons", int'(buttons), 8'hA5);

        // Bad stop bit: error pulse, and the frame does not count toward debounce.
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("t4_hold", int'(buttons), 8'hA5);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("t4_buttons", int'(buttons), 8'h5A);

        // Watchdog expiry and recovery.
        send_frame(8'hFF, 1'b1, 1'b0);
        rise_cyc = cyc + LAT;
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(rise_cyc + TO - 1 - cyc);
        check("t5_link_last", int'(link_ok), 1);
        idle(1);
        check("t5_link_drop", int'(link_ok), 0);
        check("t5_buttons_hold", int'(buttons), 8'hFF);
        send_frame(8'hFF, 1'b1, 1'b0);
        check("t5_link_back", int'(link_ok), 1);
        check("t5_buttons", int'(buttons), 8'hFF);

        // Reset in data bit 3 of an 0x81 frame, released while the line is high.
        put_bit(1'b0);
        put_bit(1'b1);
        put_bit(1'b0);
        put_bit(1'b0);
        readline = 1'b0;
        idle(5);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_buttons", int'(buttons), 0);
        check("t6_async_link", int'(link_ok), 0);
        check("t6_async_valid", int'(buttons_valid), 0);
        check("t6_async_ferr", int'(frame_error), 0);
        @(posedge clk);
        #1;
        idle(10);
        put_bit(1'b0);
        put_bit(1'b0);
        put_bit(1'b0);
        readline = 1'b1;
        idle(6);
        reset = 1'b0;
        idle(10);
        put_bit(1'b1);
        idle(200);
        check("t6_tail_link", int'(link_ok), 0);
        check("t6_tail_buttons", int'(buttons), 0);
        send_frame(8'h81, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b1);
        check("t6_buttons", int'(buttons), 8'h81);
        check("t6_link", int'(link_ok), 1);

        idle(20);
        check("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
